// File: rtl/bench_ctrl_gen_pkg.sv
// bench_ctrl_pkg -- shared definitions for the bench control generator.
//   chan_state_e : per-channel FSM state codes (IDLE=00, RUN=01, HOLD=10, DONE=11)
//   DEF_NCH      : default channel count
//   DEF_CNT_W    : default per-channel counter width
package bench_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } chan_state_e;

  localparam int DEF_NCH   = 4;
  localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/bench_ctrl_gen_if.sv
// bench_ctrl_gen_if -- control/status bundle of the bench control generator.
//   clr, start[NCH], stop[NCH], len[NCH*CNT_W], scan_en, scan_in : to the block
//   scan_out, state_o[2*NCH], cnt[NCH*CNT_W], busy[NCH], done[NCH],
//   any_busy                                                    : from the block
// master = stimulus side, slave = generator side.
interface bench_ctrl_gen_if
  import bench_ctrl_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W
);
  logic                 clr;
  logic [NCH-1:0]       start;
  logic [NCH-1:0]       stop;
  logic [NCH*CNT_W-1:0] len;
  logic                 scan_en;
  logic                 scan_in;
  logic                 scan_out;
  logic [2*NCH-1:0]     state_o;
  logic [NCH*CNT_W-1:0] cnt;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;
  logic                 any_busy;

  modport master (
    output clr, start, stop, len, scan_en, scan_in,
    input  scan_out, state_o, cnt, busy, done, any_busy
  );

  modport slave (
    input  clr, start, stop, len, scan_en, scan_in,
    output scan_out, state_o, cnt, busy, done, any_busy
  );
endinterface

// File: rtl/bench_ctrl_gen_chan.sv
// bench_ctrl_chan -- one channel: Moore FSM, down-counter and local scan segment.
//   blif_clk_net, blif_reset_net : clock, async active-high reset
//   i_clr                        : synchronous clear
//   i_start, i_stop, i_len       : channel controls
//   i_scan_en, i_scan_in         : scan shift enable / serial in
//   o_scan_out                   : serial out (counter MSB)
//   o_state, o_cnt               : registered state code and counter
module bench_ctrl_chan
  import bench_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SCAN  = 1
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_scan_en,
  input  logic             i_scan_in,
  output logic             o_scan_out,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int W = CNT_W + 2;

  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;

  // Segment order from scan_in: state bit0, state bit1, cnt LSB..MSB.
  logic [W-1:0] w_chain;
  logic [W-1:0] w_shift;
  assign w_chain = {r_cnt, r_state};
  assign w_shift = {w_chain[W-2:0], i_scan_in};

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if ((SCAN != 0) && i_scan_en) begin
      r_state <= chan_state_e'(w_shift[1:0]);
      r_cnt   <= w_shift[W-1:2];
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              r_state <= ST_RUN;
              r_cnt   <= i_len;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          // A scan load can leave RUN with cnt=0; finish instead of wrapping.
          if (i_stop) begin
            r_state <= ST_HOLD;
          end else if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (!i_stop) r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_scan_out = r_cnt[CNT_W-1];
  assign o_state    = r_state;
  assign o_cnt      = r_cnt;
endmodule

// File: rtl/bench_ctrl_gen.sv
// bench_ctrl_gen -- NCH independent run-length channels with a shared scan chain.
//   blif_clk_net   : clock, rising edge
//   blif_reset_net : asynchronous active-high reset
//   bus            : bench_ctrl_gen_if.slave (controls in, state/cnt/busy/done out)
// Status outputs decode straight from channel flops, so there is no
// combinational input-to-output path.
module bench_ctrl_gen
  import bench_ctrl_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SCAN  = 1
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  bench_ctrl_gen_if.slave  bus
);
  wire [NCH:0]           w_scan;
  wire [2*NCH-1:0]       w_state_all;
  wire [NCH*CNT_W-1:0]   w_cnt_all;
  logic [NCH-1:0]        w_busy;
  logic [NCH-1:0]        w_done;

  assign w_scan[0] = bus.scan_in;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    bench_ctrl_chan #(
      .CNT_W (CNT_W),
      .SCAN  (SCAN)
    ) u_chan (
      .blif_clk_net   (blif_clk_net),
      .blif_reset_net (blif_reset_net),
      .i_clr          (bus.clr),
      .i_start        (bus.start[gi]),
      .i_stop         (bus.stop[gi]),
      .i_len          (bus.len[gi*CNT_W +: CNT_W]),
      .i_scan_en      (bus.scan_en),
      .i_scan_in      (w_scan[gi]),
      .o_scan_out     (w_scan[gi+1]),
      .o_state        (w_state_all[2*gi +: 2]),
      .o_cnt          (w_cnt_all[gi*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    w_busy = '0;
    w_done = '0;
    for (int i = 0; i < NCH; i++) begin
      w_busy[i] = (w_state_all[2*i +: 2] == ST_RUN) || (w_state_all[2*i +: 2] == ST_HOLD);
      w_done[i] = (w_state_all[2*i +: 2] == ST_DONE);
    end
  end

  assign bus.scan_out = (SCAN != 0) ? w_scan[NCH] : 1'b0;
  assign bus.state_o  = w_state_all;
  assign bus.cnt      = w_cnt_all;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.any_busy = |w_busy;
endmodule

// File: doc/bench_ctrl_gen.md
BENCH_CTRL_GEN -- requirements
Module: bench_ctrl_gen

Interface
REQ-001 Parameter NCH, default 4, number of independent channels (1..16).
REQ-002 Parameter CNT_W, default 5, per-channel down-counter width (2..8).
REQ-003 Parameter SCAN, default 1: 1 = scan chain present; 0 = scan_en ignored and scan_out tied 0.
REQ-004 blif_clk_net  in  1  clock; all flops rising-edge.
REQ-005 blif_reset_net  in  1  reset, asynchronous, active-high.
REQ-006 clr  in  1  synchronous clear of all state and counter flops.
REQ-007 start  in  NCH  per-channel start request.
REQ-008 stop  in  NCH  per-channel pause request.
REQ-009 len  in  NCH*CNT_W  per-channel run length; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-010 scan_en  in  1  scan shift enable.
REQ-011 scan_in  in  1  scan serial input.
REQ-012 scan_out  out  1  scan serial output.
REQ-013 state_o  out  2*NCH  per-channel state code, 2 bits per channel.
REQ-014 cnt  out  NCH*CNT_W  per-channel counter value.
REQ-015 busy  out  NCH  channel state is RUN or HOLD.
REQ-016 done  out  NCH  channel state is DONE.
REQ-017 any_busy  out  1  OR of busy.

Function
REQ-018 Each channel SHALL be a Moore FSM: IDLE=00, RUN=01, HOLD=10, DONE=11; busy/done/state_o/cnt decode directly from flops, with no combinational input-to-output path.
REQ-019 Next-state priority SHALL be: clr (all flops load 0) > scan_en (shift) > normal operation.
REQ-020 IDLE: start=1 and len!=0 -> RUN with cnt<=len; start=1 and len=0 -> DONE with cnt unchanged (0); otherwise stay IDLE.
REQ-021 RUN: stop=1 -> HOLD, cnt held; else cnt==1 -> DONE with cnt<=0; else cnt<=cnt-1, stay RUN.
REQ-022 stop=1 in the same cycle as cnt==1 in RUN SHALL go to HOLD with cnt held at 1.
REQ-023 HOLD: stop=0 -> RUN, cnt unchanged that cycle; stop=1 -> stay HOLD.
REQ-024 DONE SHALL last exactly one cycle, then -> IDLE unconditionally; start during DONE is ignored.
REQ-025 start is ignored in RUN, HOLD and DONE; stop is ignored in IDLE and DONE.
REQ-026 Timing: start sampled at edge k with len=L>=1 -> busy=1 from edge k, DONE after edge k+L, IDLE after edge k+L+1, absent stop.
REQ-027 cnt arithmetic is unsigned modulo 2^CNT_W; decrement never occurs from 0.
REQ-028 Channels SHALL be fully independent; simultaneous start on all channels is legal.
REQ-029 Scan chain order: channel 0 state bit0, state bit1, cnt LSB..MSB, then channel 1, ... ; scan_in feeds channel 0 state bit0; scan_out = channel NCH-1 cnt MSB; length NCH*(2+CNT_W).
REQ-030 In scan shift every chain flop SHALL load its predecessor, with no FSM evaluation; on scan_en deassertion the FSM resumes from the shifted-in values.

Reset
REQ-031 blif_reset_net=1 SHALL force all state to IDLE and all cnt to 0 immediately: state_o=0, cnt=0, busy=0, done=0, any_busy=0, scan_out=0.
REQ-032 Reset or clr asserted mid-run SHALL abort without emitting a done pulse.

Structure
REQ-033 A shared package bench_ctrl_pkg SHALL hold the state encoding constants and the default NCH/CNT_W values.
REQ-034 One sub-module, bench_ctrl_chan, implements one channel (FSM, counter, local scan segment); the top generates NCH instances and chains their scan ports.

Verification
REQ-035 Reset, then channel 0 start=1, len=3 for one cycle -> state RUN with cnt 3,2,1 on three consecutive cycles, then DONE for 1 cycle with cnt=0, then IDLE.
REQ-036 Channel 1 len=5; stop=1 when cnt=3 for 4 cycles -> HOLD with cnt=3 for 4 cycles; after stop drops, DONE arrives 3 RUN cycles later.
REQ-037 start=1 with len=0 -> DONE on the next cycle, busy never asserted.
REQ-038 All 4 channels started with len=7, clr=1 at the 4th cycle -> next cycle all state_o=0, cnt=0, and no done pulse ever occurs.
REQ-039 scan_en=1: shift 28 bits of pattern 0xA5A5A5A and read it back on scan_out 28 cycles later; load channel 2 as RUN with cnt=2, release scan_en -> DONE two cycles later.
REQ-040 Async reset asserted between clock edges during RUN -> outputs go to 0 before the next edge.
